sort_sched: RTL and testbench

Sequential sort scheduler that time-shares a single K-bit magnitude comparator to sort a block of N unsigned words, ascending or descending. It runs bubble passes with early termination. It sits between a valid/ready producer and a valid/ready consumer and buffers one full block internally. It is the first sequenced user of the magnitude-compare datapath: the comparator itself stays combinational, and this block schedules which operand pair it sees each cycle.

---
 rtl/sort_pkg.sv | 13 +
 rtl/sort_sched_if.sv | 23 ++
 rtl/mag_gt_cmp.sv | 21 ++
 rtl/sort_sched.sv | 124 ++++++++++++
 tb/tb_sort_sched.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared types for the sort scheduler: FSM states and sort-order encodings.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

endpackage

// File: rtl/sort_sched_if.sv
// Producer/consumer handshake bundle for sort_sched; the DUT side is the slave modport.
interface sort_sched_if #(
    parameter int K = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         desc;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, desc, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, desc, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mag_gt_cmp.sv
// Combinational unsigned strict greater-than, rippling an equal/greater chain from the MSB down.
module mag_gt_cmp #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         gt
);
    logic gt_acc;
    logic eq_acc;

    always_comb begin
        gt_acc = 1'b0;
        eq_acc = 1'b1;
        for (int i = K - 1; i >= 0; i--) begin
            gt_acc = gt_acc | (eq_acc & a[i] & ~b[i]);
            eq_acc = eq_acc & ~(a[i] ^ b[i]);
        end
        gt = gt_acc;
    end
endmodule

// File: rtl/sort_sched.sv
// Block sorter: buffers N words, bubble-sorts them with one shared comparator and early exit, then drains.
module sort_sched
    import sort_pkg::*;
#(
    parameter int K = 8,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sort_sched_if.slave  bus
);
    localparam int            W      = $clog2(N);
    localparam logic [W-1:0]  LAST   = W'(N - 1);
    localparam logic [W-1:0]  LAST_J = W'(N - 2);

    logic [K-1:0] mem [N];
    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] wr_idx;
    logic [W-1:0] j;
    logic [W-1:0] pass;
    logic [W-1:0] rd_idx;
    logic         swapped;
    logic         order;

    logic [W-1:0] j_nxt;
    logic [K-1:0] op_a;
    logic [K-1:0] op_b;
    logic         gt;
    logic         accept;
    logic         xfer;
    logic         end_pass;
    logic         sort_done;

    assign j_nxt = j + W'(1);

    // Descending order crosses the operands so the same strict gt decides the swap.
    assign op_a = (order == ASC)  ? mem[j] : mem[j_nxt];
    assign op_b = (order == DESC) ? mem[j] : mem[j_nxt];

    mag_gt_cmp #(.K(K)) u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (gt)
    );

    assign accept    = (state == LOAD)  && bus.in_valid;
    assign xfer      = (state == DRAIN) && bus.out_ready;
    assign end_pass  = (j == LAST_J);
    assign sort_done = end_pass && (!(swapped || gt) || (pass == LAST_J));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && (wr_idx == LAST)) state_nxt = SORT;
            SORT:    if (sort_done)                  state_nxt = DRAIN;
            DRAIN:   if (xfer && (rd_idx == LAST))   state_nxt = LOAD;
            default:                                 state_nxt = LOAD;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == LOAD);
        bus.out_valid = (state == DRAIN);
        bus.busy      = (state != LOAD);
        bus.out_data  = mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            j       <= '0;
            pass    <= '0;
            rd_idx  <= '0;
            swapped <= 1'b0;
            order   <= ASC;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    if (wr_idx == '0) order <= bus.desc;
                    if (wr_idx == LAST) begin
                        wr_idx  <= '0;
                        j       <= '0;
                        pass    <= '0;
                        swapped <= 1'b0;
                    end else begin
                        wr_idx <= wr_idx + W'(1);
                    end
                end
                SORT: begin
                    if (gt) swapped <= 1'b1;
                    if (!end_pass) begin
                        j <= j_nxt;
                    end else if (sort_done) begin
                        rd_idx <= '0;
                    end else begin
                        pass    <= pass + W'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                DRAIN: if (xfer) begin
                    rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + W'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage carries no reset; a swap rewrites both neighbours on the same edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= bus.in_data;
        end else if ((state == SORT) && gt) begin
            mem[j]     <= mem[j_nxt];
            mem[j_nxt] <= mem[j];
        end
    end
endmodule

// File: tb/tb_sort_sched.sv
// Directed bench for sort_sched: scoreboard of reference-sorted blocks, N=8/K=8 plus an N=2/K=1 instance.
module tb_sort_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sort_sched_if #(.K(8)) ia ();
    sort_sched_if #(.K(1)) ib ();

    sort_sched #(.K(8), .N(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    sort_sched #(.K(1), .N(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] blk [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] w [8], input logic d, input bit flip, input bit rnd);
        logic [7:0] s [8];
        logic [7:0] t;
        int i = 0;
        int guard = 0;
        s = w;
        for (int a = 1; a < 8; a++)
            for (int b = a; b > 0; b--)
                if (d ? (s[b] > s[b-1]) : (s[b] < s[b-1])) begin
                    t = s[b]; s[b] = s[b-1]; s[b-1] = t;
                end
        for (int k = 0; k < 8; k++) exp_q.push_back(s[k]);
        while (i < 8 && guard < 200) begin
            ia.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ia.in_data  = w[i];
            ia.desc     = (flip && i > 0) ? ~d : d;
            if (rnd) check("in_ready_load", ia.in_ready, 1);
            tick();
            if (ia.in_valid) i++;
            guard++;
        end
        ia.in_valid = 1'b0;
        check("load_count", i, 8);
    endtask

    task automatic sort_wait(input int expc);
        int cyc = 0;
        while (!ia.out_valid && cyc < 300) begin
            check("busy_sort", ia.busy, 1);
            check("in_ready_sort", ia.in_ready, 0);
            tick();
            cyc++;
        end
        if (expc >= 0) check("sort_cycles", cyc, expc);
        else           check("sort_finished", ia.out_valid, 1);
    endtask

    task automatic drain_a(input int cnt, input bit rnd);
        int got = 0;
        int guard = 0;
        bit stalled = 0;
        logic [7:0] held = '0;
        while (got < cnt && guard < 400) begin
            ia.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) check("stall_stable", ia.out_data, held);
            stalled = 0;
            if (ia.out_valid) begin
                check("busy_drain", ia.busy, 1);
                check("in_ready_drain", ia.in_ready, 0);
                if (ia.out_ready) begin
                    check("out_data", ia.out_data, exp_q.pop_front());
                    got++;
                end else begin
                    stalled = 1;
                    held    = ia.out_data;
                end
            end
            tick();
            guard++;
        end
        ia.out_ready = 1'b0;
        check("drain_count", got, cnt);
    endtask

    task automatic post_block();
        check("post_in_ready", ia.in_ready, 1);
        check("post_out_valid", ia.out_valid, 0);
        check("post_busy", ia.busy, 0);
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_in_ready"}, ia.in_ready, 1);
        check({tag, "_out_valid"}, ia.out_valid, 0);
        check({tag, "_busy"}, ia.busy, 0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        ia.in_valid = 0; ia.in_data = '0; ia.desc = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.in_data = '0; ib.desc = 0; ib.out_ready = 0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", ia.in_ready, 1);
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_busy", ia.busy, 0);
        #2 rst_n = 1'b1;
        tick();

        blk = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_a(blk, 1'b0, 0, 0);
        sort_wait(7);
        drain_a(8, 0);
        post_block();

        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_a(blk, 1'b0, 0, 0);
        sort_wait(49);
        drain_a(8, 0);
        post_block();

        blk = '{8'd0, 8'd255, 8'd7, 8'd7, 8'd128, 8'd0, 8'd255, 8'd1};
        load_a(blk, 1'b1, 1, 0);
        sort_wait(-1);
        drain_a(8, 0);
        post_block();

        for (int k = 0; k < 8; k++) blk[k] = 8'($urandom_range(0, 255));
        load_a(blk, 1'b0, 0, 1);
        sort_wait(-1);
        drain_a(8, 1);
        post_block();

        blk = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_a(blk, 1'b0, 0, 0);
        for (int k = 0; k < 20; k++) tick();
        reset_now("rst_sort");

        blk = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd200, 8'd3, 8'd77, 8'd0};
        load_a(blk, 1'b1, 0, 0);
        sort_wait(-1);
        drain_a(3, 0);
        reset_now("rst_drain");

        for (int k = 0; k < 8; k++) blk[k] = 8'($urandom_range(0, 255));
        load_a(blk, 1'b0, 0, 0);
        sort_wait(-1);
        drain_a(8, 0);
        post_block();

        ib.in_valid = 1'b1; ib.in_data = 1'b1; ib.desc = 1'b0;
        tick();
        ib.in_data = 1'b0;
        tick();
        ib.in_valid = 1'b0;
        cyc = 0;
        while (!ib.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b_sort_cycles", cyc, 1);
        ib.out_ready = 1'b1;
        check("b_out0", ib.out_data, 0);
        tick();
        check("b_out1", ib.out_data, 1);
        check("b_valid1", ib.out_valid, 1);
        tick();
        ib.out_ready = 1'b0;
        check("b_in_ready", ib.in_ready, 1);
        check("b_busy", ib.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
